// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for load/store (D), instruction fetch (I) and program loader (L).
// One transaction at a time. D has fixed priority, and I/L alternate round-robin.
module mem_port_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          d_gnt,
    output logic          i_gnt,
    output logic          l_gnt,
    output logic          d_done,
    output logic          i_done,
    output logic          l_done,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic [1:0] {OWN_D, OWN_I, OWN_L} owner_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          rr_q, rr_d;          // 0: I favoured, 1: L favoured
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    gnt_q, gnt_d;        // {L, I, D}
    logic [2:0]    done_q, done_d;
    logic          err_q, err_d;

    function automatic logic [2:0] owner_oh(input owner_t o);
        case (o)
            OWN_D:   owner_oh = 3'b001;
            OWN_I:   owner_oh = 3'b010;
            OWN_L:   owner_oh = 3'b100;
            default: owner_oh = 3'b000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!halt && (d_req || i_req || l_req)) begin
                    if (d_req)
                        owner_d = OWN_D;
                    else if (i_req && (!l_req || !rr_q))
                        owner_d = OWN_I;
                    else
                        owner_d = OWN_L;
                    case (owner_d)
                        OWN_D: begin
                            mem_we_d    = d_we;
                            mem_addr_d  = d_addr;
                            mem_wdata_d = d_wdata;
                        end
                        OWN_I: begin
                            mem_we_d    = 1'b0;
                            mem_addr_d  = i_addr;
                            mem_wdata_d = '0;
                            rr_d        = 1'b1;
                        end
                        default: begin
                            mem_we_d    = l_we;
                            mem_addr_d  = l_addr;
                            mem_wdata_d = l_wdata;
                            rr_d        = 1'b0;
                        end
                    endcase
                    gnt_d     = owner_oh(owner_d);
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the timeout cycle still counts as a clean completion.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = owner_oh(owner_q);
                    if (!mem_we_q)
                        rdata_d = mem_rdata;
                    state_d   = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    done_d    = owner_oh(owner_q);
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign d_gnt      = gnt_q[0];
    assign i_gnt      = gnt_q[1];
    assign l_gnt      = gnt_q[2];
    assign d_done     = done_q[0];
    assign i_done     = done_q[1];
    assign l_done     = done_q[2];
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed
// scenarios with hand-computed latencies, grant order and data.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          halt = 1'b0;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          d_gnt, i_gnt, l_gnt, d_done, i_done, l_done;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_req(i_req), .i_addr(i_addr),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .d_gnt(d_gnt), .i_gnt(i_gnt), .l_gnt(l_gnt),
        .d_done(d_done), .i_done(i_done), .l_done(l_done),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requesters: each holds req while it has outstanding requests; a grant consumes one.
    int d_cnt = 0, i_cnt = 0, l_cnt = 0;
    initial forever begin
        @(posedge clk); #2;
        if (d_gnt && d_cnt > 0) d_cnt--;
        if (i_gnt && i_cnt > 0) i_cnt--;
        if (l_gnt && l_cnt > 0) l_cnt--;
        d_req = (d_cnt > 0);
        i_req = (i_cnt > 0);
        l_req = (l_cnt > 0);
    end

    // Memory: acks in the ack_lat-th cycle of mem_req (0 = never); idle_ack injects stray acks.
    int ack_lat = 1;
    int req_cyc = 0;
    bit idle_ack = 1'b0;
    logic [DW-1:0] rd_val = '0;
    initial forever begin
        @(posedge clk); #2;
        if (mem_req && !mem_ack) begin
            req_cyc++;
            if (ack_lat != 0 && req_cyc == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_val;
            end
        end else begin
            mem_ack = idle_ack && !mem_req;
            req_cyc = 0;
        end
    end

    // Model: a transaction is either open or not; it closes on ack or after TO cycles.
    logic [2:0]    e_gnt = '0, e_done = '0;
    logic          e_err = 1'b0, e_req = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_rdata = '0;
    bit            busy = 1'b0, fav_l = 1'b0;
    int            own = 0, age = 0;

    task automatic model_step();
        int w;
        if (!rst_n) begin
            e_gnt = '0; e_done = '0; e_err = 1'b0; e_req = 1'b0; e_we = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
            busy = 1'b0; fav_l = 1'b0; age = 0;
            return;
        end
        e_gnt = '0; e_done = '0; e_err = 1'b0;
        if (!busy) begin
            if (!halt && (d_req || i_req || l_req)) begin
                w = d_req ? 0 : ((i_req && (!l_req || !fav_l)) ? 1 : 2);
                case (w)
                    0: begin e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; end
                    1: begin e_we = 1'b0; e_addr = i_addr; e_wdata = '0; fav_l = 1'b1; end
                    default: begin e_we = l_we; e_addr = l_addr; e_wdata = l_wdata; fav_l = 1'b0; end
                endcase
                own = w; busy = 1'b1; age = 0; e_req = 1'b1;
                e_gnt = 3'b100 >> w;
            end
        end else begin
            age++;
            if (mem_ack || age == TO) begin
                busy = 1'b0; e_req = 1'b0;
                e_done = 3'b100 >> own;
                e_err = !mem_ack;
                if (mem_ack && !e_we) e_rdata = mem_rdata;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("gnt", {d_gnt, i_gnt, l_gnt}, e_gnt);
        chk("done", {d_done, i_done, l_done}, e_done);
        chk("resp_err", resp_err, e_err);
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    // Monitor: grant order log and length of the last mem_req burst.
    int glog[$];
    int req_run = 0, last_run = 0;
    initial forever begin
        @(negedge clk);
        if (d_gnt) glog.push_back(0);
        if (i_gnt) glog.push_back(1);
        if (l_gnt) glog.push_back(2);
        if (mem_req) req_run++;
        else begin
            if (req_run != 0) last_run = req_run;
            req_run = 0;
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0: return d_gnt;
            1: return i_gnt;
            2: return l_gnt;
            3: return d_done;
            4: return i_done;
            5: return l_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int which, input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (sig(which)) return;
            if (n >= budget) begin
                tests++;
                fails++;
                $display("FAIL wait_%s: not seen within %0d cycles", nm, budget);
                n = -1;
                return;
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {d_gnt, i_gnt, l_gnt, d_done, i_done, l_done, resp_err, mem_req, mem_we}, 0);
        chk({nm, "_bus"}, {mem_addr, mem_wdata, resp_rdata}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sz;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single D store, zero-wait memory
        d_we = 1'b1; d_addr = 10'h005; d_wdata = 32'hDEADBEEF; ack_lat = 1;
        d_cnt = 1;
        wait_for("d_gnt", 0, 6, n);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 10'h005);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        wait_for("d_done", 3, 6, n);
        chk("st_lat", n, 1);
        chk("st_rdata", resp_rdata, 0);
        chk("st_err", resp_err, 0);

        // Fetch with three wait states
        i_addr = 10'h010; rd_val = 32'h2800000A; ack_lat = 4;
        i_cnt = 1;
        wait_for("i_gnt", 1, 6, n);
        chk("fe_we", mem_we, 0);
        wait_for("i_done", 4, 8, n);
        chk("fe_lat", n, 4);
        chk("fe_rdata", resp_rdata, 32'h2800000A);
        chk("fe_err", resp_err, 0);
        @(negedge clk);
        chk("fe_req_len", last_run, 4);

        // D load acked exactly on the timeout cycle
        d_we = 1'b0; d_addr = 10'h02A; rd_val = 32'h12345678; ack_lat = TO;
        d_cnt = 1;
        wait_for("d_gnt", 0, 6, n);
        wait_for("d_done", 3, 8, n);
        chk("edge_lat", n, TO);
        chk("edge_err", resp_err, 0);
        chk("edge_rdata", resp_rdata, 32'h12345678);

        // Loader write, memory never acks: timeout
        l_we = 1'b1; l_addr = 10'h3FF; l_wdata = 32'hA5A5A5A5; ack_lat = 0;
        l_cnt = 1;
        wait_for("l_gnt", 2, 6, n);
        wait_for("l_done", 5, 10, n);
        chk("to_lat", n, TO);
        chk("to_err", resp_err, 1);
        chk("to_rdata", resp_rdata, 32'h12345678);
        @(negedge clk);
        chk("to_req_len", last_run, TO);
        chk("to_err_clr", resp_err, 0);
        ack_lat = 1; i_addr = 10'h020; rd_val = 32'h0000BEEF;
        i_cnt = 1;
        wait_for("i_gnt_after_to", 1, 6, n);
        wait_for("i_done_after_to", 4, 6, n);
        chk("post_to_rdata", resp_rdata, 32'h0000BEEF);
        chk("post_to_err", resp_err, 0);

        // Stray acks while idle must not produce completions
        idle_ack = 1'b1;
        repeat (4) @(negedge clk);
        idle_ack = 1'b0;
        repeat (2) @(negedge clk);

        // halt: in-flight D completes, pending I waits
        d_we = 1'b0; d_addr = 10'h007; rd_val = 32'h77777777; ack_lat = 3;
        d_cnt = 1;
        wait_for("d_gnt_halt", 0, 6, n);
        halt = 1'b1; i_addr = 10'h030;
        i_cnt = 1;
        wait_for("d_done_halt", 3, 8, n);
        chk("halt_lat", n, 3);
        chk("halt_rdata", resp_rdata, 32'h77777777);
        sz = glog.size();
        repeat (5) @(negedge clk);
        chk("halt_no_gnt", glog.size(), sz);
        halt = 1'b0; ack_lat = 1;
        wait_for("i_gnt_unhalt", 1, 6, n);
        wait_for("i_done_unhalt", 4, 6, n);

        // Reset pulsed mid-ACCESS
        l_we = 1'b0; l_addr = 10'h100; ack_lat = 0;
        l_cnt = 1;
        wait_for("l_gnt_rst", 2, 6, n);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Contention after reset: D first, then I (rr reset), L, D again, I, L
        glog.delete();
        ack_lat = 1; d_we = 1'b1; d_addr = 10'h001; d_wdata = 32'h11111111;
        l_we = 1'b1; l_addr = 10'h002; l_wdata = 32'h22222222; i_addr = 10'h003;
        d_cnt = 1; i_cnt = 2; l_cnt = 1;
        wait_for("l_gnt_c1", 2, 20, n);
        d_cnt = 1; l_cnt = 1;
        wait_for("l_gnt_c2", 2, 20, n);
        wait_for("l_done_c2", 5, 6, n);
        chk("order_len", glog.size(), 6);
        if (glog.size() == 6) begin
            chk("order_0", glog[0], 0);
            chk("order_1", glog[1], 1);
            chk("order_2", glog[2], 2);
            chk("order_3", glog[3], 0);
            chk("order_4", glog[4], 1);
            chk("order_5", glog[5], 2);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
